// File: rtl/instr_encoder_loader.sv
// Packs MIPS field tuples into 32-bit words, queues them in a small FIFO and
// streams them sequentially into instruction memory over a req/ack write port.
module instr_encoder_loader #(
  parameter int          ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          DEPTH     = 4,
  parameter int          MAX_WORDS = 256,
  localparam int         CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_format,
  input  logic [5:0]        i_op,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_shamt,
  input  logic [5:0]        i_funct,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  input  logic [31:0]       i_raw,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  input  logic              i_mem_ack,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_busy,
  output logic              o_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [OCC_W-1:0]   r_occ;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        w_word;
  logic [31:0]        w_pending;
  logic               w_ready;
  logic               w_mem_wr;
  logic               w_push;
  logic               w_pop;
  logic               w_last;

  // Field packing; fields not used by the selected format are ignored.
  always_comb begin
    w_word = 32'h0000_0000;
    case (i_format)
      2'b00:   w_word = {i_op, i_rs, i_rt, i_rd, i_shamt, i_funct};
      2'b01:   w_word = {i_op, i_rs, i_rt, i_imm};
      2'b10:   w_word = {i_op, i_target};
      default: w_word = i_raw;
    endcase
  end

  // Words queued but not yet committed count against the session limit.
  assign w_pending = 32'(r_count) + 32'(r_occ);
  assign w_ready   = (r_state == ST_RUN) && (r_occ != OCC_W'(DEPTH)) &&
                     (w_pending < 32'(MAX_WORDS));
  assign w_mem_wr  = (r_state == ST_RUN) && (r_occ != OCC_W'(0));
  assign w_push    = i_in_valid && w_ready && !i_start;
  assign w_pop     = w_mem_wr && i_mem_ack && !i_start;
  assign w_last    = (r_count == CNT_W'(MAX_WORDS - 1));

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; Start restarts a session from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_pop && w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Encoded-word FIFO; Start flushes it and drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (i_start) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_word;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - OCC_W'(1);
      end else begin
        r_occ <= r_occ;
      end
    end
  end

  // Commit counter and write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_addr  <= ADDR_W'(BASE_ADDR);
    end else if (i_start) begin
      r_count <= '0;
      r_addr  <= ADDR_W'(BASE_ADDR);
    end else if (w_pop) begin
      r_count <= r_count + CNT_W'(1);
      r_addr  <= r_addr + ADDR_W'(4);
    end else begin
      r_count <= r_count;
      r_addr  <= r_addr;
    end
  end

  assign o_in_ready = w_ready;
  assign o_mem_wr   = w_mem_wr;
  assign o_mem_addr = r_addr;
  assign o_mem_data = r_mem[r_rptr];
  assign o_count    = r_count;
  assign o_busy     = (r_state == ST_RUN);
  assign o_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader, checked against a
// queue-based reference model of the loader session.
module tb_instr_encoder_loader;

  localparam int          ADDR_W = 32;
  localparam int unsigned BASE   = 32'h0000_0100;
  localparam int          DEPTH  = 4;
  localparam int          MAXW   = 8;
  localparam int          CNT_W  = $clog2(MAXW + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        fmt = 2'b00;
  logic [5:0]        op = 6'd0;
  logic [4:0]        rs = 5'd0;
  logic [4:0]        rt = 5'd0;
  logic [4:0]        rd = 5'd0;
  logic [4:0]        shamt = 5'd0;
  logic [5:0]        funct = 6'd0;
  logic [15:0]       imm = 16'd0;
  logic [25:0]       target = 26'd0;
  logic [31:0]       raw = 32'd0;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_ack = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  instr_encoder_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH), .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_format(fmt), .i_op(op), .i_rs(rs), .i_rt(rt),
    .i_rd(rd), .i_shamt(shamt), .i_funct(funct), .i_imm(imm),
    .i_target(target), .i_raw(raw), .o_mem_wr(mem_wr),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data), .i_mem_ack(mem_ack),
    .o_count(count), .o_busy(busy), .o_done(done)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Reference model: session flags, committed count and queue of pending words.
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  int          m_count = 0;
  logic [31:0] q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: observed 0x%0h, expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word();
    case (fmt)
      2'b00:   return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
                      (32'(rd) << 11) | (32'(shamt) << 6) | 32'(funct);
      2'b01:   return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      2'b10:   return (32'(op) << 26) | 32'(target);
      default: return raw;
    endcase
  endfunction

  function automatic bit m_ready();
    return m_run && (q.size() < DEPTH) && ((m_count + q.size()) < MAXW);
  endfunction

  function automatic bit m_wr();
    return m_run && (q.size() > 0);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_done = 1'b0; m_count = 0; q.delete();
  endtask

  task automatic compare_all();
    check_eq("in_ready", in_ready, m_ready());
    check_eq("mem_wr", mem_wr, m_wr());
    if (m_wr()) check_eq("mem_data", mem_data, q[0]);
    check_eq("mem_addr", mem_addr, BASE + 4 * m_count);
    check_eq("count", count, m_count);
    check_eq("busy", busy, m_run);
    check_eq("done", done, m_done);
  endtask

  task automatic check_reset();
    check_eq("rst.in_ready", in_ready, 0);
    check_eq("rst.mem_wr", mem_wr, 0);
    check_eq("rst.mem_addr", mem_addr, BASE);
    check_eq("rst.mem_data", mem_data, 0);
    check_eq("rst.count", count, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
  endtask

  // Advance the model with the inputs currently driven, clock once, compare.
  task automatic tick();
    bit          do_pop;
    bit          do_push;
    logic [31:0] w;
    w = ref_word();
    if (start) begin
      q.delete(); m_count = 0; m_run = 1'b1; m_done = 1'b0;
    end else if (m_run) begin
      do_pop  = (q.size() > 0) && mem_ack;
      do_push = in_valid && m_ready();
      if (do_pop) begin
        void'(q.pop_front());
        m_count++;
      end
      if (do_push) q.push_back(w);
      if (do_pop && m_count == MAXW) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit s, input bit v, input bit a);
    start = s; in_valid = v; mem_ack = a;
  endtask

  task automatic set_r(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f);
    fmt = 2'b00; op = o; rs = s; rt = t; rd = d; shamt = sh; funct = f;
  endtask

  task automatic set_rand();
    fmt = 2'($urandom); op = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); shamt = 5'($urandom); funct = 6'($urandom);
    imm = 16'($urandom); target = 26'($urandom); raw = $urandom;
  endtask

  initial begin
    // Reset values
    phase = "reset";
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all();

    // R-format round trip and first commit
    phase = "t1";
    set_r(6'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20);
    drive(1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0); tick();
    check_eq("r_word", mem_data, 32'h0109_5020);
    check_eq("r_addr", mem_addr, BASE);
    check_eq("r_wr", mem_wr, 1);
    drive(1'b0, 1'b0, 1'b1); tick();
    check_eq("r_count", count, 1);
    check_eq("r_addr_next", mem_addr, BASE + 4);

    // I, J, RAW formats with continuous ack
    phase = "t2";
    fmt = 2'b01; op = 6'h23; rs = 5'd29; rt = 5'd8; imm = 16'hFFFC;
    drive(1'b0, 1'b1, 1'b1); tick();
    check_eq("i_word", mem_data, 32'h8FA8_FFFC);
    check_eq("i_addr", mem_addr, BASE + 4);
    fmt = 2'b10; op = 6'h02; target = 26'h010_0000; tick();
    check_eq("j_word", mem_data, 32'h0810_0000);
    check_eq("j_addr", mem_addr, BASE + 8);
    fmt = 2'b11; raw = 32'hDEAD_BEEF; tick();
    check_eq("raw_word", mem_data, 32'hDEAD_BEEF);
    check_eq("raw_addr", mem_addr, BASE + 12);
    drive(1'b0, 1'b0, 1'b1); tick();
    check_eq("t2_count", count, 4);

    // Back-pressure: ack withheld, FIFO fills to DEPTH
    phase = "t3";
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_rand(); tick();
    end
    check_eq("full_ready", in_ready, 0);
    check_eq("full_wr", mem_wr, 1);
    drive(1'b0, 1'b0, 1'b1); tick();
    check_eq("ready_after_pop", in_ready, 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    check_eq("t3_count", count, DEPTH);

    // Session limit reached while streaming
    phase = "t4";
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30 && !m_done; i++) begin
      set_rand(); tick();
    end
    check_eq("done_reached", done, 1);
    check_eq("done_wr", mem_wr, 0);
    check_eq("done_addr", mem_addr, BASE + 4 * MAXW);
    check_eq("done_ready", in_ready, 0);
    repeat (3) tick();

    // Start mid-session drops queued words and the pending write
    phase = "t5";
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0);
    set_rand(); tick();
    set_rand(); tick();
    check_eq("pre_start_wr", mem_wr, 1);
    drive(1'b1, 1'b1, 1'b1); tick();
    check_eq("flush_wr", mem_wr, 0);
    check_eq("flush_count", count, 0);
    check_eq("flush_addr", mem_addr, BASE);
    drive(1'b0, 1'b1, 1'b0); set_rand(); tick();
    drive(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized sessions
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      set_rand();
      drive(($urandom_range(31) == 0) || (i == 0), $urandom_range(9) < 6, $urandom_range(1) == 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
